// File: rtl/debounce_pulse.sv
// rtl/debounce_pulse.sv - per-channel level debouncer with registered rise/fall pulses
// Each channel runs an independent LOW/CHECK_HIGH/HIGH/CHECK_LOW FSM with its own run counter.
module debounce_pulse #(
  parameter int WIDTH         = 1,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_rise
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {LOW, CHECK_HIGH, HIGH, CHECK_LOW} state_t;

  logic [WIDTH-1:0] rise_qual;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] count;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;

    // Same qualifying condition the FSM uses to enter HIGH; feeds the shared any_rise register.
    assign rise_qual[i] = (state == CHECK_HIGH) && sync_in[i] && (count == LAST);

    always_ff @(posedge clk) begin
      if (!reset) begin
        state   <= LOW;
        count   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state)
          LOW: begin
            if (sync_in[i]) begin
              state <= CHECK_HIGH;
              count <= CW'(1);
            end else begin
              count <= '0;
            end
          end
          CHECK_HIGH: begin
            if (!sync_in[i]) begin
              state <= LOW;
              count <= '0;
            end else if (count == LAST) begin
              state   <= HIGH;
              count   <= '0;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
          HIGH: begin
            if (!sync_in[i]) begin
              state <= CHECK_LOW;
              count <= CW'(1);
            end else begin
              count <= '0;
            end
          end
          CHECK_LOW: begin
            if (sync_in[i]) begin
              state <= HIGH;
              count <= '0;
            end else if (count == LAST) begin
              state   <= LOW;
              count   <= '0;
              level_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
          default: begin
            state   <= LOW;
            count   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign level[i] = level_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      any_rise <= 1'b0;
    end else begin
      any_rise <= |rise_qual;
    end
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// tb/tb_debounce_pulse.sv - randomized and directed bench for debounce_pulse
// Reference model tracks, per channel, the length of the current run of samples differing from level.
module tb_debounce_pulse;
  localparam int W  = 4;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] sync_in = '0;
  logic [W-1:0] level, rise, fall;
  logic         any_rise;

  debounce_pulse #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .sync_in(sync_in),
    .level(level), .rise(rise), .fall(fall), .any_rise(any_rise)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  logic [W-1:0] m_level = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;
  logic         m_any = 1'b0;
  int           m_run [W];

  task automatic step(input logic r, input logic [W-1:0] d);
    @(negedge clk);
    reset = r;
    sync_in = d;
    @(posedge clk);
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < W; c++) begin
      if (!r) begin
        m_level[c] = 1'b0;
        m_run[c] = 0;
      end else if (d[c] != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == SC) begin
          m_level[c] = d[c];
          m_run[c] = 0;
          if (d[c]) m_rise[c] = 1'b1;
          else m_fall[c] = 1'b1;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_any = |m_rise;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'b1111);
      n_checks++;
      if ({level, rise, fall, any_rise} !== 13'b0)
        $display("FAIL reset_hold cyc%0d: level=%b rise=%b fall=%b any=%b expected all zero", i, level, rise, fall, any_rise);
      else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b1111);
      n_checks++;
      if (i < 3 && {level, rise, any_rise} !== 9'b0)
        $display("FAIL reset_release_early cyc%0d: level=%b rise=%b any=%b expected 0", i, level, rise, any_rise);
      else if (i == 3 && (level !== 4'b1111 || rise !== 4'b1111 || any_rise !== 1'b1))
        $display("FAIL reset_release_rise: level=%b rise=%b any=%b expected 1111 1111 1", level, rise, any_rise);
      else if (i == 4 && (level !== 4'b1111 || rise !== 4'b0000 || any_rise !== 1'b0))
        $display("FAIL reset_release_after: level=%b rise=%b any=%b expected 1111 0000 0", level, rise, any_rise);
      else n_pass++;
    end
  endtask

  task automatic test_single_rise();
    step(1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0001);
      n_checks++;
      if (i < 3 && (level !== 4'b0000 || rise !== 4'b0000))
        $display("FAIL single_rise_wait cyc%0d: level=%b rise=%b expected 0000 0000", i, level, rise);
      else if (i == 3 && (level !== 4'b0001 || rise !== 4'b0001))
        $display("FAIL single_rise_edge: level=%b rise=%b expected 0001 0001", level, rise);
      else if (i == 4 && (level !== 4'b0001 || rise !== 4'b0000))
        $display("FAIL single_rise_width: level=%b rise=%b expected 0001 0000", level, rise);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (i < 3) ? 4'b0000 : 4'b0001);
      n_checks++;
      if (level !== 4'b0001 || fall !== 4'b0000)
        $display("FAIL glitch cyc%0d: level=%b fall=%b expected 0001 0000", i, level, fall);
      else n_pass++;
    end
  endtask

  task automatic test_multi();
    step(1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b1010);
      n_checks++;
      if (i < 3 && (rise !== 4'b0000 || any_rise !== 1'b0 || level !== 4'b0000))
        $display("FAIL multi_wait cyc%0d: level=%b rise=%b any=%b expected 0000 0000 0", i, level, rise, any_rise);
      else if (i == 3 && (rise !== 4'b1010 || any_rise !== 1'b1 || level !== 4'b1010))
        $display("FAIL multi_rise: level=%b rise=%b any=%b expected 1010 1010 1", level, rise, any_rise);
      else if (i == 4 && (rise !== 4'b0000 || any_rise !== 1'b0))
        $display("FAIL multi_rise_width: rise=%b any=%b expected 0000 0", rise, any_rise);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b0000);
      n_checks++;
      if (i < 3 && (fall !== 4'b0000 || level !== 4'b1010))
        $display("FAIL multi_fall_wait cyc%0d: level=%b fall=%b expected 1010 0000", i, level, fall);
      else if (i == 3 && (fall !== 4'b1010 || level !== 4'b0000 || rise !== 4'b0000))
        $display("FAIL multi_fall: level=%b fall=%b rise=%b expected 0000 1010 0000", level, fall, rise);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_check();
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0100);
    step(1'b1, 4'b0100);
    step(1'b0, 4'b0100);
    n_checks++;
    if (level !== 4'b0000 || rise !== 4'b0000)
      $display("FAIL reset_mid_check: level=%b rise=%b expected 0000 0000", level, rise);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b0100);
      n_checks++;
      if (rise[2] !== (i == 3) || level[2] !== (i == 3))
        $display("FAIL reset_mid_recount cyc%0d: rise[2]=%b level[2]=%b expected %b", i, rise[2], level[2], (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    int pulses = 0;
    int at = -1;
    step(1'b0, 4'b0000);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, {pat[i][0], 3'b000});
      if (rise[3] === 1'b1) begin
        pulses++;
        at = i;
      end
    end
    step(1'b1, 4'b1000);
    if (rise[3] === 1'b1) pulses++;
    n_checks++;
    if (pulses != 1 || at != 8)
      $display("FAIL bounce: rise[3] pulses=%0d at sample %0d expected 1 at 8", pulses, at);
    else n_pass++;
    n_checks++;
    if (level !== 4'b1000)
      $display("FAIL bounce_level: level=%b expected 1000", level);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] cur = '0;
    int hold [W];
    logic r;
    for (int c = 0; c < W; c++) hold[c] = 0;
    step(1'b0, 4'b0000);
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < W; c++) begin
        if (hold[c] == 0) begin
          cur[c] = $urandom_range(0, 1);
          hold[c] = $urandom_range(1, 7);
        end
        hold[c]--;
      end
      r = ($urandom_range(0, 79) != 0);
      step(r, cur);
      n_checks++;
      if (level !== m_level || rise !== m_rise || fall !== m_fall || any_rise !== m_any || (rise & fall) !== 4'b0)
        $display("FAIL random cyc%0d: level=%b rise=%b fall=%b any=%b expected %b %b %b %b", n, level, rise, fall, any_rise, m_level, m_rise, m_fall, m_any);
      else n_pass++;
    end
  endtask

  initial begin
    for (int c = 0; c < W; c++) m_run[c] = 0;
    test_reset();
    test_single_rise();
    test_glitch();
    test_multi();
    test_reset_mid_check();
    test_bounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
